// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter sharing a binary-tree mux between requesters
module rr_mux_arbiter #(
  parameter int level     = 4,
  parameter int data_sz   = 4,
  parameter int sel_sz    = 3,
  parameter int max_burst = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [(1<<(level-1))-1:0]             req_valid,
  input  logic [(1<<(level-1))*data_sz-1:0]     req_data,
  input  logic [(1<<(level-1))-1:0]             req_last,
  output logic [(1<<(level-1))-1:0]             req_ready,
  output logic                                  out_valid,
  output logic [data_sz-1:0]                    out_data,
  output logic                                  out_last,
  output logic [sel_sz-1:0]                     out_sel,
  input  logic                                  out_ready,
  output logic                                  busy
);

  localparam int NREQ = 1 << (level - 1);
  localparam int SW   = level - 1;
  localparam int BW   = $clog2(max_burst + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(max_burst - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   ptr, ptr_nxt;
  logic [SW-1:0]   gnt, gnt_nxt;
  logic [BW-1:0]   beats, beats_nxt;
  logic [SW-1:0]   pick, cand;
  logic            found;
  logic [data_sz-1:0] mux_out;

  // Binary-tree mux: the deepest level holds the requester words, each upper
  // level halves the candidates using one grant bit, MSB at the root.
  for (genvar d = 0; d < level; d++) begin : g_lvl
    logic [data_sz-1:0] node [1<<d];
    if (d == level - 1) begin : g_leaf
      for (genvar i = 0; i < (1 << d); i++) begin : g_in
        assign node[i] = req_data[i*data_sz +: data_sz];
      end
    end else begin : g_inner
      for (genvar j = 0; j < (1 << d); j++) begin : g_sel
        assign node[j] = gnt[SW-1-d] ? g_lvl[d+1].node[2*j+1] : g_lvl[d+1].node[2*j];
      end
    end
  end
  assign mux_out = g_lvl[0].node[0];

  assign out_sel = sel_sz'(gnt);

  // Scan upward from ptr with wraparound and take the first valid requester.
  always_comb begin
    pick  = ptr;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + SW'(k);
      if (!found && req_valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  // State, pointer, grant and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      beats <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      beats <= beats_nxt;
    end
  end

  // Next-state and handshake outputs; the grant is held until a last beat is taken.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    beats_nxt = beats;
    req_ready = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = (state == LOCK);
    case (state)
      IDLE: begin
        if (found) begin
          gnt_nxt   = pick;
          beats_nxt = '0;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        out_valid      = req_valid[gnt];
        req_ready[gnt] = out_ready;
        out_last       = req_last[gnt] || (beats == LAST_BEAT);
        out_data       = mux_out;
        if (out_valid && out_ready) begin
          if (out_last) begin
            beats_nxt = '0;
            ptr_nxt   = gnt + SW'(1);
            state_nxt = IDLE;
          end else begin
            beats_nxt = beats + BW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - directed self-checking bench for rr_mux_arbiter
module tb_rr_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req_valid;
  logic [31:0] req_data;
  logic [7:0]  req_last;
  logic [7:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic        out_last;
  logic [2:0]  out_sel;
  logic        out_ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // slice i carries 15-i, so requester 0 -> F, 7 -> 8
  localparam logic [31:0] DATA = 32'h89AB_CDEF;

  rr_mux_arbiter #(.level(4), .data_sz(4), .sel_sz(3), .max_burst(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_sel(out_sel), .out_ready(out_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [7:0] valid;
    logic [7:0] last;
    logic       rdy;
    logic       e_valid;
    logic [2:0] e_sel;
    logic [7:0] e_ready;
    logic       e_last;
    logic       e_busy;
    logic [3:0] e_data;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(bit rst, logic [7:0] v, logic [7:0] l, logic r,
                              logic ev, logic [2:0] es, logic [7:0] er,
                              logic el, logic eb, logic [3:0] ed);
    vec_t t;
    t.rst = rst; t.valid = v; t.last = l; t.rdy = r;
    t.e_valid = ev; t.e_sel = es; t.e_ready = er;
    t.e_last = el; t.e_busy = eb; t.e_data = ed;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int m;
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = DATA;
    out_ready = 1'b0;

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last, 0);
    chk("rst_out_sel",   out_sel, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_req_ready", req_ready, 0);

    // round robin: all valid, single-beat packets, one grant every 2 cycles
    for (int k = 0; k < 18; k++) begin
      m = k / 2;
      if (k % 2 == 0)
        tbl.push_back(mk(k == 0, 8'hFF, 8'hFF, 1'b1, 1'b0,
                         (k == 0) ? 3'd0 : 3'(m - 1), 8'h00, 1'b0, 1'b0, 4'h0));
      else
        tbl.push_back(mk(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 3'(m),
                         8'h01 << (m % 8), 1'b1, 1'b1, 4'(15 - (m % 8))));
    end
    // sparse wrap 0x81: grants 0,7,0,7
    tbl.push_back(mk(1, 8'h00, 8'hFF, 1, 0, 3'd0, 8'h00, 0, 0, 4'h0));
    tbl.push_back(mk(0, 8'h81, 8'hFF, 1, 0, 3'd0, 8'h00, 0, 0, 4'h0));
    tbl.push_back(mk(0, 8'h81, 8'hFF, 1, 1, 3'd0, 8'h01, 1, 1, 4'hF));
    tbl.push_back(mk(0, 8'h81, 8'hFF, 1, 0, 3'd0, 8'h00, 0, 0, 4'h0));
    tbl.push_back(mk(0, 8'h81, 8'hFF, 1, 1, 3'd7, 8'h80, 1, 1, 4'h8));
    tbl.push_back(mk(0, 8'h81, 8'hFF, 1, 0, 3'd7, 8'h00, 0, 0, 4'h0));
    tbl.push_back(mk(0, 8'h81, 8'hFF, 1, 1, 3'd0, 8'h01, 1, 1, 4'hF));
    tbl.push_back(mk(0, 8'h81, 8'hFF, 1, 0, 3'd0, 8'h00, 0, 0, 4'h0));
    tbl.push_back(mk(0, 8'h81, 8'hFF, 1, 1, 3'd7, 8'h80, 1, 1, 4'h8));

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      req_valid = tbl[i].valid;
      req_last  = tbl[i].last;
      out_ready = tbl[i].rdy;
      #1;
      chk("tbl_out_valid", out_valid, tbl[i].e_valid);
      chk("tbl_out_sel",   out_sel,   tbl[i].e_sel);
      chk("tbl_req_ready", req_ready, tbl[i].e_ready);
      chk("tbl_out_last",  out_last,  tbl[i].e_last);
      chk("tbl_busy",      busy,      tbl[i].e_busy);
      chk("tbl_out_data",  out_data,  tbl[i].e_data);
      tick();
    end

    // burst limit: requester 3 streams without req_last
    do_reset();
    req_valid = 8'h08; req_last = 8'h00; out_ready = 1'b1;
    #1 chk("burst_idle_busy", busy, 0);
    tick();
    for (int b = 0; b < 8; b++) begin
      #1;
      chk("burst1_sel",  out_sel, 3);
      chk("burst1_last", out_last, (b == 7));
      tick();
    end
    #1 chk("burst_bubble_busy", busy, 0);
    tick();
    for (int b = 0; b < 8; b++) begin
      #1;
      chk("burst2_sel",  out_sel, 3);
      chk("burst2_last", out_last, (b == 7));
      tick();
    end
    req_valid = 8'h0A;
    #1 chk("burst_bubble2_busy", busy, 0);
    tick();
    #1 chk("burst_other_wins", out_sel, 1);

    // backpressure on requester 4 after two accepted beats
    do_reset();
    req_valid = 8'h10; req_last = 8'h00; out_ready = 1'b1;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    req_valid = 8'h12;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_req_ready", req_ready, 8'h00);
      chk("bp_out_data",  out_data, 4'hB);
      chk("bp_out_sel",   out_sel, 4);
      chk("bp_out_valid", out_valid, 1);
      tick();
    end
    out_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      #1;
      chk("bp_req_ready_rel", req_ready, 8'h10);
      chk("bp_forced_last",   out_last, (b == 5));
      tick();
    end
    #1 chk("bp_bubble_busy", busy, 0);
    tick();
    #1;
    chk("bp_next_sel",  out_sel, 1);
    chk("bp_next_data", out_data, 4'hE);

    // dropout: requester 2 drops valid for 3 cycles mid-packet
    do_reset();
    req_valid = 8'h04; req_last = 8'h00; out_ready = 1'b1;
    tick();
    #1 chk("drop_sel", out_sel, 2);
    tick();
    req_valid = 8'h00;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("drop_out_valid", out_valid, 0);
      chk("drop_busy",      busy, 1);
      chk("drop_out_sel",   out_sel, 2);
      tick();
    end
    req_valid = 8'h04; req_last = 8'h04;
    #1;
    chk("drop_resume_valid", out_valid, 1);
    chk("drop_resume_last",  out_last, 1);
    chk("drop_resume_data",  out_data, 4'hD);
    tick();
    #1 chk("drop_done_busy", busy, 0);

    // asynchronous reset mid-burst with gnt=5
    do_reset();
    req_valid = 8'h20; req_last = 8'h00; out_ready = 1'b1;
    tick();
    tick();
    #1 chk("arst_pre_sel", out_sel, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_sel",   out_sel, 0);
    chk("arst_busy",      busy, 0);
    chk("arst_req_ready", req_ready, 0);
    req_valid = 8'hFF; req_last = 8'hFF;
    tick();
    rst_n = 1'b1;
    #1 chk("arst_release_busy", busy, 0);
    tick();
    #1;
    chk("arst_restart_sel",  out_sel, 0);
    chk("arst_restart_busy", busy, 1);
    chk("arst_restart_data", out_data, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
